// File: rtl/sfu_accum.sv
// rtl/sfu_accum.sv - multi-pass psum accumulator with saturating add and ReLU drain
module sfu_accum #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [3:0]             cfg_passes,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [col*psum_bw-1:0] in_psum,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [col*psum_bw-1:0] out_data,
   output logic                   busy,
   output logic                   done
);

   localparam int AW = $clog2(depth);
   localparam logic [AW-1:0] LAST_ADDR = AW'(depth - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t                 state;
   logic [AW-1:0]          addr;
   logic [3:0]             pass_cnt;
   logic [3:0]             passes_q;
   logic [col*psum_bw-1:0] buf_q [depth];
   logic [col*psum_bw-1:0] rd_row;
   logic [col*psum_bw-1:0] acc_row;

   function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b);
      logic [psum_bw:0] s;
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      // Disagreeing top two bits of the extended sum mean signed overflow.
      if (s[psum_bw] != s[psum_bw-1])
         return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      return s[psum_bw-1:0];
   endfunction

   assign rd_row = buf_q[addr];

   always_comb begin
      acc_row = in_psum;
      if (pass_cnt != 4'd0) begin
         for (int k = 0; k < col; k++)
            acc_row[k*psum_bw +: psum_bw] = sat_add(rd_row[k*psum_bw +: psum_bw],
                                                    in_psum[k*psum_bw +: psum_bw]);
      end
   end

   always_comb begin
      out_data = '0;
      if (state == DRAIN) begin
         for (int k = 0; k < col; k++)
            out_data[k*psum_bw +: psum_bw] = rd_row[k*psum_bw + psum_bw - 1] ?
                                             '0 : rd_row[k*psum_bw +: psum_bw];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr      <= '0;
         pass_cnt  <= 4'd0;
         passes_q  <= 4'd0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < depth; i++)
            buf_q[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCUM;
                  passes_q <= (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
                  addr     <= '0;
                  pass_cnt <= 4'd0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  buf_q[addr] <= acc_row;
                  if (addr == LAST_ADDR) begin
                     addr     <= '0;
                     pass_cnt <= pass_cnt + 4'd1;
                     if (pass_cnt == passes_q - 4'd1) begin
                        state     <= DRAIN;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                     end
                  end else begin
                     addr <= addr + AW'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (addr == LAST_ADDR) begin
                     state     <= IDLE;
                     addr      <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     addr <= addr + AW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfu_accum.sv
// tb/tb_sfu_accum.sv - directed and randomized bench for sfu_accum against an arithmetic model
module tb_sfu_accum;

   localparam int COL = 8;
   localparam int BW  = 16;
   localparam int DEP = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [3:0]       cfg_passes;
   logic             in_valid;
   logic             in_ready;
   logic [COL*BW-1:0] in_psum;
   logic             out_valid;
   logic             out_ready;
   logic [COL*BW-1:0] out_data;
   logic             busy;
   logic             done;

   int checks = 0;
   int failures = 0;

   logic [COL*BW-1:0] rows [$];
   int mdl [DEP][COL];

   sfu_accum #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_passes(cfg_passes),
      .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [COL*BW-1:0] obs, input logic [COL*BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [COL*BW-1:0] rnd_row();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_out_data"}, out_data, 0);
   endtask

   // Reference: pass 0 overwrites, later passes add with clamping to the signed 16-bit range.
   task automatic model_job(input int eff);
      for (int p = 0; p < eff; p++)
         for (int a = 0; a < DEP; a++)
            for (int l = 0; l < COL; l++) begin
               int v;
               v = int'($signed(rows[p*DEP + a][l*BW +: BW]));
               if (p == 0) mdl[a][l] = v;
               else begin
                  mdl[a][l] = mdl[a][l] + v;
                  if (mdl[a][l] > 32767) mdl[a][l] = 32767;
                  if (mdl[a][l] < -32768) mdl[a][l] = -32768;
               end
            end
   endtask

   function automatic logic [COL*BW-1:0] exp_row(input int a);
      logic [COL*BW-1:0] e;
      for (int l = 0; l < COL; l++)
         e[l*BW +: BW] = (mdl[a][l] < 0) ? 16'h0 : 16'(mdl[a][l]);
      return e;
   endfunction

   task automatic begin_job(input logic [3:0] cfg);
      start = 1'b1; cfg_passes = cfg; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      start = 1'b0;
      check("job_in_ready", in_ready, 1);
      check("job_busy", busy, 1);
      check("job_out_valid", out_valid, 0);
      check("job_done", done, 0);
   endtask

   // Feeds rows[0..n-1] with random gaps and stray start pulses that must be ignored.
   task automatic feed(input int n, input bit full);
      int idx = 0;
      int guard = 0;
      bit acc;
      while (idx < n && guard < 5000) begin
         in_valid   = ($urandom_range(3) != 0);
         in_psum    = rows[idx];
         start      = ($urandom_range(7) == 0);
         cfg_passes = 4'($urandom_range(15));
         acc = in_valid && in_ready;
         tick();
         if (acc) idx++;
         guard++;
      end
      start = 1'b0; in_valid = 1'b0;
      check("feed_count", 128'(idx), 128'(n));
      if (full) begin
         check("drain_in_ready", in_ready, 0);
         check("drain_out_valid", out_valid, 1);
         check("drain_busy", busy, 1);
      end
   endtask

   task automatic drain();
      int k = 0;
      int guard = 0;
      bit xfer;
      bit stalled = 1'b0;
      logic [COL*BW-1:0] prev;
      while (k < DEP && guard < 5000) begin
         check("drain_valid", out_valid, 1);
         if (stalled) check("drain_stable", out_data, prev);
         check($sformatf("drain_data[%0d]", k), out_data, exp_row(k));
         out_ready = ($urandom_range(2) != 0);
         in_valid  = $urandom_range(1);
         in_psum   = rnd_row();
         xfer = out_ready && out_valid;
         prev = out_data;
         stalled = !xfer;
         tick();
         guard++;
         if (xfer) k++;
         if (k < DEP) check("drain_no_done", done, 0);
      end
      out_ready = 1'b0; in_valid = 1'b0;
      check("drain_count", 128'(k), 128'(DEP));
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_out_valid", out_valid, 0);
      check("end_out_data", out_data, 0);
   endtask

   task automatic run_job(input logic [3:0] cfg);
      int eff;
      eff = (cfg == 4'd0) ? 1 : int'(cfg);
      model_job(eff);
      begin_job(cfg);
      feed(eff * DEP, 1'b1);
      drain();
   endtask

   task automatic rows_lane0(input int v);
      for (int a = 0; a < DEP; a++) begin
         logic [COL*BW-1:0] r;
         r = rnd_row();
         r[BW-1:0] = 16'(v);
         rows.push_back(r);
      end
   endtask

   task automatic rows_const(input logic [BW-1:0] v);
      for (int a = 0; a < DEP; a++)
         rows.push_back({COL{v}});
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; cfg_passes = 4'd0; in_valid = 1'b0;
      out_ready = 1'b0; in_psum = '0;

      // Reset held with random activity on the inputs.
      for (int i = 0; i < 12; i++) begin
         start = $urandom_range(1); in_valid = $urandom_range(1);
         out_ready = $urandom_range(1); in_psum = rnd_row();
         cfg_passes = 4'($urandom_range(15));
         tick();
         check_quiet("reset");
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      reset = 1'b1;

      // in_valid in IDLE is not accepted.
      in_valid = 1'b1; in_psum = rnd_row();
      tick(); tick();
      check_quiet("idle");
      in_valid = 1'b0;

      // Single pass, lane k = addr*8+k.
      rows.delete();
      for (int a = 0; a < DEP; a++) begin
         logic [COL*BW-1:0] r;
         for (int l = 0; l < COL; l++) r[l*BW +: BW] = 16'(a*8 + l);
         rows.push_back(r);
      end
      run_job(4'd1);

      // Three passes: lane0 +5,-3,-4 -> ReLU(-2)=0; then +5,+5,-3 -> 7.
      rows.delete(); rows_lane0(5); rows_lane0(-3); rows_lane0(-4);
      run_job(4'd3);
      check("p3_lane0_zero", out_data[BW-1:0], 0);
      rows.delete(); rows_lane0(5); rows_lane0(5); rows_lane0(-3);
      model_job(3);
      check("p3_model_seven", 128'(mdl[DEP-1][0]), 128'(7));
      run_job(4'd3);

      // Saturation in both directions.
      rows.delete(); rows_const(16'h7000); rows_const(16'h7000);
      model_job(2);
      check("sat_pos", exp_row(0), {COL{16'h7FFF}});
      run_job(4'd2);
      rows.delete(); rows_const(16'h9000); rows_const(16'h9000);
      model_job(2);
      check("sat_neg", 128'(mdl[3][2]), 128'(-32768));
      run_job(4'd2);

      // Random jobs with handshake stalls.
      for (int j = 0; j < 4; j++) begin
         int np;
         np = $urandom_range(1, 4);
         rows.delete();
         for (int i = 0; i < np*DEP; i++) rows.push_back(rnd_row());
         run_job(4'(np));
      end

      // Reset mid-job at pass 1, addr 7, then a cfg_passes=0 job.
      rows.delete();
      for (int i = 0; i < 2*DEP; i++) rows.push_back(rnd_row());
      begin_job(4'd2);
      feed(DEP + 7, 1'b0);
      check("mid_busy", busy, 1);
      reset = 1'b0;
      #1;
      check_quiet("async_reset");
      for (int i = 0; i < 3; i++) begin
         in_valid = $urandom_range(1); start = $urandom_range(1);
         tick();
         check_quiet("mid_reset");
      end
      start = 1'b0; in_valid = 1'b0;
      reset = 1'b1;
      tick();
      check_quiet("post_reset");
      rows.delete();
      for (int i = 0; i < DEP; i++) rows.push_back(rnd_row());
      run_job(4'd0);
      tick();
      check("final_done_clear", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
